// File: rtl/hazard_if.sv
// hazard_if: groups the pipeline-side signals of the hazard controller.
//   master : the pipeline (drives IF/ID instruction, ID/EX load info,
//            branch resolution; receives stall/flush controls and status)
//   slave  : the hazard unit
// Signals:
//   IFID_inst[31:0]    instruction held in IF/ID
//   IDEX_MemRead       ID/EX instruction is a load
//   IDEX_rd[4:0]       ID/EX destination register
//   branch_taken       EX resolved a taken branch/jump
//   PCWrite            PC may update
//   IFIDWrite          IF/ID may load
//   IF_flush           IF/ID loads a NOP
//   IDEX_bubble        ID/EX loads control zeros
//   mdu_busy           MDU occupancy counter nonzero
//   stall_cycles[31:0] stalled-cycle counter
interface hazard_if;
  logic [31:0] IFID_inst;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_rd;
  logic        branch_taken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IF_flush;
  logic        IDEX_bubble;
  logic        mdu_busy;
  logic [31:0] stall_cycles;

  modport master (
    output IFID_inst, IDEX_MemRead, IDEX_rd, branch_taken,
    input  PCWrite, IFIDWrite, IF_flush, IDEX_bubble, mdu_busy, stall_cycles
  );

  modport slave (
    input  IFID_inst, IDEX_MemRead, IDEX_rd, branch_taken,
    output PCWrite, IFIDWrite, IF_flush, IDEX_bubble, mdu_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller.
// Detects load-use hazards between IF/ID and ID/EX, stalls M-extension
// instructions while the non-pipelined MDU is occupied, and applies
// taken-branch flushes with top priority. Keeps a stalled-cycle counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   hif    hazard_if.slave (pipeline inputs, stall/flush outputs, status)
// Parameter:
//   MDU_LAT  MDU occupancy in cycles per M instruction (>=1)
module hazard_unit #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hif
);

  localparam int unsigned     CNT_W    = $clog2(MDU_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  logic [6:0] op;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_mdu;
  logic       load_use;
  logic       mdu_stall;
  logic       issue;

  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [31:0]      stall_q, stall_d;

  logic pc_write, ifid_write, if_flush, idex_bubble;

  // rd/funct3 fields of the ID instruction play no part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^hif.IFID_inst[14:7];

  assign op     = hif.IFID_inst[6:0];
  assign rs1    = hif.IFID_inst[19:15];
  assign rs2    = hif.IFID_inst[24:20];
  assign funct7 = hif.IFID_inst[31:25];

  assign uses_rs1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  assign uses_rs2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
  assign is_mdu   = (op == 7'b0110011) && (funct7 == 7'b0000001);

  // x0 is never a real dependency, so a load targeting x0 cannot stall.
  assign load_use = hif.IDEX_MemRead && (hif.IDEX_rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == hif.IDEX_rd)) ||
                     (uses_rs2 && (rs2 == hif.IDEX_rd)));

  assign mdu_stall = is_mdu && (mdu_cnt_q != '0);

  // Only an instruction that actually moves into EX occupies the MDU.
  assign issue = rst_n && !hif.branch_taken && !load_use && !mdu_stall;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      if_flush    = 1'b1;
      idex_bubble = 1'b1;
    end else if (hif.branch_taken) begin
      if_flush    = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use || mdu_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (issue && is_mdu) begin
      mdu_cnt_d = CNT_LOAD;
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
    end
    stall_d = stall_q;
    if (!pc_write) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdu_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign hif.PCWrite      = pc_write;
  assign hif.IFIDWrite    = ifid_write;
  assign hif.IF_flush     = if_flush;
  assign hif.IDEX_bubble  = idex_bubble;
  assign hif.mdu_busy     = (mdu_cnt_q != '0);
  assign hif.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  localparam int unsigned LAT = 4;

  localparam logic [31:0] ADD_X7 = 32'h006283B3;
  localparam logic [31:0] LUI_X6 = 32'h00028337;
  localparam logic [31:0] MUL_X1 = 32'h023100B3;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic clk;
  logic rst_n;

  hazard_if hif ();

  hazard_unit #(.MDU_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  // negedge at 5, posedge at 10, ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        busy;
    logic [31:0] stalls;
    bit          chk_state;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: MDU is free from cycle free_at onward.
  longint      cyc = 0;
  longint      free_at = 0;
  logic [31:0] m_stalls = 0;
  bit          known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle-vector %0d: got %h expected %h", name, vectors, act, exp);
    end
  endtask

  // Monitor: the DUT presents a settled response every cycle mid-period.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      chk("PCWrite",     {31'd0, hif.PCWrite},     {31'd0, e.pcw});
      chk("IFIDWrite",   {31'd0, hif.IFIDWrite},   {31'd0, e.ifw});
      chk("IF_flush",    {31'd0, hif.IF_flush},    {31'd0, e.fl});
      chk("IDEX_bubble", {31'd0, hif.IDEX_bubble}, {31'd0, e.bub});
      if (e.chk_state) begin
        chk("mdu_busy",     {31'd0, hif.mdu_busy}, {31'd0, e.busy});
        chk("stall_cycles", hif.stall_cycles,      e.stalls);
      end
    end
  end

  task automatic apply(input bit rn, input logic [31:0] inst, input bit mr,
                       input logic [4:0] rd, input bit bt);
    exp_t e;
    logic [6:0] op;
    logic [4:0] r1, r2;
    bit u1, u2, mdu, lu, busy, ms, iss;
    rst_n            = rn;
    hif.IFID_inst    = inst;
    hif.IDEX_MemRead = mr;
    hif.IDEX_rd      = rd;
    hif.branch_taken = bt;

    op   = inst[6:0];
    r1   = inst[19:15];
    r2   = inst[24:20];
    u1   = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2   = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    mdu  = (op == 7'h33) && (inst[31:25] == 7'h01);
    lu   = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    busy = (cyc < free_at);
    ms   = mdu && busy;
    iss  = rn && !bt && !lu && !ms;

    if (!rn)            begin e.pcw = 0; e.ifw = 0; e.fl = 1; e.bub = 1; end
    else if (bt)        begin e.pcw = 1; e.ifw = 1; e.fl = 1; e.bub = 1; end
    else if (lu || ms)  begin e.pcw = 0; e.ifw = 0; e.fl = 0; e.bub = 1; end
    else                begin e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0; end
    e.busy      = busy;
    e.stalls    = m_stalls;
    e.chk_state = known;
    q.push_back(e);

    @(posedge clk);
    if (!rn) begin
      free_at  = 0;
      m_stalls = 0;
      known    = 1;
    end else begin
      if (iss && mdu) free_at = cyc + LAT;
      if (!e.pcw) m_stalls = m_stalls + 1;
    end
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [9];
    logic [6:0] op, f7;
    ops = '{7'h33, 7'h23, 7'h63, 7'h03, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
    op = ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 2))
      0:       f7 = 7'h01;
      1:       f7 = 7'h00;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom), op};
  endfunction

  initial begin
    // reset
    repeat (3) apply(0, NOP, 0, 0, 0);
    // load-use, then the bubble has cleared MemRead
    apply(1, ADD_X7, 1, 5, 0);
    apply(1, ADD_X7, 0, 0, 0);
    // load to x0: no stall
    apply(1, ADD_X7, 1, 0, 0);
    // LUI has no rs1 dependency
    apply(1, LUI_X6, 1, 5, 0);
    // back-to-back muls: 3 stall cycles, then issue
    apply(1, MUL_X1, 0, 0, 0);
    repeat (4) apply(1, MUL_X1, 0, 0, 0);
    repeat (4) apply(1, NOP, 0, 0, 0);
    // non-M instruction during MDU window passes
    apply(1, MUL_X1, 0, 0, 0);
    apply(1, ADD_X7, 0, 0, 0);
    repeat (4) apply(1, NOP, 0, 0, 0);
    // flush overrides load-use; squashed mul does not occupy MDU
    apply(1, ADD_X7, 1, 5, 1);
    apply(1, MUL_X1, 0, 0, 1);
    apply(1, MUL_X1, 0, 0, 0);
    repeat (4) apply(1, NOP, 0, 0, 0);
    // reset mid-MDU, then a mul issues immediately
    apply(1, MUL_X1, 0, 0, 0);
    apply(1, NOP, 0, 0, 0);
    apply(0, MUL_X1, 0, 0, 0);
    apply(1, MUL_X1, 0, 0, 0);
    apply(1, MUL_X1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 99) >= 2), rand_inst(),
            ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 12));
    end
    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller driving the front end's stall/flush inputs (PCWrite, IFIDWrite, IF_flush) and the ID/EX bubble select. It inspects the instruction held in IF/ID against the load in ID/EX and against a non-pipelined multiply/divide unit (MDU) occupancy counter. It also takes the taken-branch resolution from EX. It sits between the IF/ID register, the ID/EX register and the PC logic, and keeps a stall-cycle performance counter.

## Interface
- MDU_LAT, 4, MDU occupancy in cycles per M-extension instruction (≥1; 1 = never stalls)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- IFID_inst  in  32  instruction currently in IF/ID
- IDEX_MemRead  in  1  instruction in ID/EX is a load
- IDEX_rd  in  5  destination register of instruction in ID/EX
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- PCWrite  out  1  1 = PC may update
- IFIDWrite  out  1  1 = IF/ID may load
- IF_flush  out  1  1 = IF/ID loads NOP
- IDEX_bubble  out  1  1 = ID/EX loads control zeros
- mdu_busy  out  1  MDU occupancy counter nonzero
- stall_cycles  out  32  count of stalled cycles

## Operation
- Decode from IFID_inst: op=[6:0], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- uses_rs1: op not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- uses_rs2: op in {0110011, 0100011, 1100011}.
- is_mdu: op=0110011 and funct7=0000001.
- load_use = IDEX_MemRead & IDEX_rd≠0 & ((uses_rs1 & rs1==IDEX_rd) | (uses_rs2 & rs2==IDEX_rd)).
- mdu_stall = is_mdu & mdu_cnt≠0.
- Outputs are combinational (Mealy) with this priority:
  - rst_n=0: PCWrite=0, IFIDWrite=0, IF_flush=1, IDEX_bubble=1.
  - branch_taken: PCWrite=1, IFIDWrite=1, IF_flush=1, IDEX_bubble=1. Overrides load_use and mdu_stall.
  - load_use | mdu_stall: PCWrite=0, IFIDWrite=0, IF_flush=0, IDEX_bubble=1.
  - Otherwise: PCWrite=1, IFIDWrite=1, IF_flush=0, IDEX_bubble=0.
- issue = rst_n & !branch_taken & !load_use & !mdu_stall. The ID instruction advances to EX this cycle.
- mdu_cnt, width clog2(MDU_LAT)+1, updated on clk edge:
  - rst_n=0: 0.
  - else if issue & is_mdu: MDU_LAT-1.
  - else if mdu_cnt≠0: mdu_cnt-1.
  - else hold.
- mdu_busy = (mdu_cnt≠0).
- An M instruction squashed by branch_taken does not load the counter. The counter keeps decrementing during flushes and load stalls.
- stall_cycles, updated on clk edge:
  - rst_n=0: 0.
  - else if PCWrite=0: +1, wrapping FFFFFFFF→0.
  - else hold.

## Timing
- Reset values after a clock edge with rst_n=0: mdu_cnt=0, mdu_busy=0, stall_cycles=0. The other outputs hold the reset values above while rst_n=0.
- Load-use stall lasts exactly 1 cycle: the bubble clears IDEX_MemRead on the next edge.
- M instruction issued in cycle N: mdu_busy=1 in cycles N+1..N+MDU_LAT-1. A following M instruction in ID stalls through those cycles and issues in cycle N+MDU_LAT. Non-M instructions are never stalled by mdu_cnt.
- Branch flush takes 1 cycle, zero stall cycles.
- Load_use and mdu_stall in the same cycle produce a single stall.
- Deasserting rst_n mid-MDU clears mdu_cnt on that edge. The first post-reset cycle runs free.
- branch_taken is never asserted while an M instruction occupies EX. If asserted in that case, the block still applies flush priority.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> PCWrite=0, IFIDWrite=0, IF_flush=1, IDEX_bubble=1, mdu_busy=0, stall_cycles=0.
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_inst=0x006283B3 (add x7,x5,x6) -> PCWrite=0, IFIDWrite=0, IDEX_bubble=1 for one cycle, then stall_cycles=1. Same with IDEX_rd=0 -> no stall.
- No false stall: IDEX_MemRead=1, IDEX_rd=5, IFID_inst=0x00028337 (lui x6, rs1 field=5) -> PCWrite=1, IDEX_bubble=0.
- MDU, MDU_LAT=4: 0x023100B3 (mul x1,x2,x3) issues at cycle N, second mul in ID at N+1 -> mdu_busy=1 and PCWrite=0 for N+1..N+3, issue at N+4, stall_cycles+=3. Non-M instruction at N+1 passes with no stall.
- Flush priority: branch_taken=1 with a load_use condition present -> IF_flush=1, IDEX_bubble=1, PCWrite=1, IFIDWrite=1, stall_cycles unchanged. Squashed mul leaves mdu_busy=0.
- Reset mid-MDU: rst_n=0 at cycle N+2 of an MDU window -> mdu_busy=0 and stall_cycles=0 after that edge. A mul in ID after rst_n=1 issues immediately.
